// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : FP32 field widths, canonical constants, flag indices and enums
//            shared by the divide sequencer and its operand classifier.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // FLAGS = {invalid, divzero, overflow, underflow}
  localparam int FLG_INVALID   = 3;
  localparam int FLG_DIVZERO   = 2;
  localparam int FLG_OVERFLOW  = 1;
  localparam int FLG_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NORM   = 3'd4,
    ST_PACK   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_t;

  function automatic logic [3:0] flag_only(input int idx);
    logic [3:0] f;
    f      = '0;
    f[idx] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] signed_inf(input logic s);
    return POS_INF | {s, 31'b0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_ctrl_if
// Purpose  : Client (START/DONE) and divider (REQ/READY) signals of the FP32
//            divide sequencer; slave = sequencer view, master = environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fdiv_ctrl_if;

  logic        START;
  logic [31:0] OPA;
  logic [31:0] OPB;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic [3:0]  FLAGS;
  logic [23:0] DIV_A;
  logic [23:0] DIV_B;
  logic        DIV_REQ;
  logic [23:0] DIV_OUT;
  logic        DIV_READY;

  modport slave (
    input  START, OPA, OPB, DIV_OUT, DIV_READY,
    output BUSY, DONE, RESULT, FLAGS, DIV_A, DIV_B, DIV_REQ
  );

  modport master (
    output START, OPA, OPB, DIV_OUT, DIV_READY,
    input  BUSY, DONE, RESULT, FLAGS, DIV_A, DIV_B, DIV_REQ
  );

endinterface
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp32_classify
// Purpose  : Combinational binary32 unpack; subnormals flush to signed zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_classify
  import fpu_pkg::*;
(
  input  logic [31:0]      op,
  output fp_class_t        cls,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [FRAC_W:0]  mant
);

  always_comb begin
    sign = op[31];
    exp  = op[30:23];
    mant = {1'b1, op[22:0]};
    cls  = CLS_NORM;
    if (op[30:23] == 8'h00) begin
      cls  = CLS_ZERO;
      mant = '0;
    end else if (op[30:23] == 8'hFF) begin
      cls = (op[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_ctrl
// Purpose  : FP32 divide sequencer around a shared iterative mantissa divider.
//            FDIV_TIMEOUT_EN adds a bounded wait on the divider (TIMEOUT cycles).
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_ctrl
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  fdiv_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [31:0]       opa_q, opa_d, opb_q, opb_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic [FRAC_W:0]   div_a_q, div_a_d, div_b_q, div_b_d, quo_q, quo_d;
  logic              div_req_q, div_req_d;
  logic              sign_q, sign_d, seen_low_q, seen_low_d;
  logic signed [9:0] exp_q, exp_d;

`ifdef FDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  fp_class_t        cls_a, cls_b;
  logic             sgn_a, sgn_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [FRAC_W:0]  man_a, man_b;

  fp32_classify u_cls_a (.op(opa_q), .cls(cls_a), .sign(sgn_a), .exp(exp_a), .mant(man_a));
  fp32_classify u_cls_b (.op(opb_q), .cls(cls_b), .sign(sgn_b), .exp(exp_b), .mant(man_b));

  // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
  logic signed [9:0] norm_exp;
  logic [FRAC_W-1:0] norm_mant;
  assign norm_exp  = quo_q[FRAC_W] ? exp_q : exp_q - 10'sd1;
  assign norm_mant = quo_q[FRAC_W] ? quo_q[FRAC_W-1:0] : {quo_q[FRAC_W-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    flags_d    = flags_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    div_req_d  = 1'b0;
    quo_d      = quo_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    seen_low_d = seen_low_q;
`ifdef FDIV_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // busy_q is still set in the DONE cycle, which blocks a same-cycle START
        busy_d = 1'b0;
        if (bus.START && !busy_q) begin
          opa_d   = bus.OPA;
          opb_d   = bus.OPB;
          busy_d  = 1'b1;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        sign_d = sgn_a ^ sgn_b;
        exp_d  = {2'b00, exp_a} - {2'b00, exp_b} + 10'(BIAS);
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
          result_d = QNAN;
          flags_d  = flag_only(FLG_INVALID);
          state_d  = ST_PACK;
        end else if (cls_a == CLS_NORM && cls_b == CLS_ZERO) begin
          result_d = signed_inf(sgn_a ^ sgn_b);
          flags_d  = flag_only(FLG_DIVZERO);
          state_d  = ST_PACK;
        end else if (cls_a == CLS_INF) begin
          result_d = signed_inf(sgn_a ^ sgn_b);
          flags_d  = '0;
          state_d  = ST_PACK;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
          result_d = signed_zero(sgn_a ^ sgn_b);
          flags_d  = '0;
          state_d  = ST_PACK;
        end else begin
          div_a_d = man_a;
          div_b_d = man_b;
          // Fold the first ISSUE cycle in here so an idle divider sees REQ at T+2
          if (bus.DIV_READY) begin
            div_req_d  = 1'b1;
            seen_low_d = 1'b0;
`ifdef FDIV_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.DIV_READY) begin
          div_req_d  = 1'b1;
          seen_low_d = 1'b0;
`ifdef FDIV_TIMEOUT_EN
          cnt_d      = '0;
`endif
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
`ifdef FDIV_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!bus.DIV_READY) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          quo_d   = bus.DIV_OUT;
          state_d = ST_NORM;
        end
`ifdef FDIV_TIMEOUT_EN
        if (state_d == ST_WAIT && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = QNAN;
          flags_d  = flag_only(FLG_INVALID);
          state_d  = ST_PACK;
        end
`endif
      end

      ST_NORM: begin
        if (norm_exp >= 10'sd255) begin
          result_d = signed_inf(sign_q);
          flags_d  = flag_only(FLG_OVERFLOW);
        end else if (norm_exp <= 10'sd0) begin
          result_d = signed_zero(sign_q);
          flags_d  = flag_only(FLG_UNDERFLOW);
        end else begin
          result_d = {sign_q, norm_exp[EXP_W-1:0], norm_mant};
          flags_d  = '0;
        end
        state_d = ST_PACK;
      end

      ST_PACK: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_req_q  <= 1'b0;
      quo_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      seen_low_q <= 1'b0;
`ifdef FDIV_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_req_q  <= div_req_d;
      quo_q      <= quo_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      seen_low_q <= seen_low_d;
`ifdef FDIV_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.RESULT  = result_q;
  assign bus.FLAGS   = flags_q;
  assign bus.DIV_A   = div_a_q;
  assign bus.DIV_B   = div_b_q;
  assign bus.DIV_REQ = div_req_q;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdiv_ctrl
// Purpose  : Directed self-checking bench for fdiv_ctrl with a behavioural
//            iterative divider model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fdiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdiv_ctrl_if bus();

  fdiv_ctrl #(.TIMEOUT(64)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Divider model: busy for div_lat cycles after an accepted REQ; ignores reset.
  bit          div_init = 1'b1;
  int          div_lat  = 6;
  int          div_cnt;
  logic [23:0] div_q_p;
  always @(posedge clk) begin
    if (div_init) begin
      bus.DIV_READY <= 1'b1;
      bus.DIV_OUT   <= '0;
      div_cnt       <= 0;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        bus.DIV_OUT   <= div_q_p;
        bus.DIV_READY <= 1'b1;
      end
    end else if (bus.DIV_REQ && bus.DIV_READY) begin
      div_q_p       <= 24'(({24'd0, bus.DIV_A} << 23) / {24'd0, bus.DIV_B});
      div_cnt       <= div_lat;
      bus.DIV_READY <= 1'b0;
    end
  end

  int req_cnt = 0, done_cnt = 0, req_busy_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus.DIV_REQ) req_cnt++;
    if (bus.DIV_REQ && !bus.DIV_READY) req_busy_cnt++;
    if (bus.DONE) done_cnt++;
  end

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] flg,
                        output int lat, output int nreq);
    int  r0;
    bit  ok, busy_bad;
    r0 = req_cnt;
    @(negedge clk);
    bus.START = 1'b1; bus.OPA = a; bus.OPB = b;
    @(negedge clk);
    bus.START = 1'b0;
    lat = 1; ok = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.BUSY) busy_bad = 1'b1;
      if (bus.DONE) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
    res  = bus.RESULT;
    flg  = bus.FLAGS;
    nreq = req_cnt - r0;
  endtask

  logic [31:0] res;
  logic [3:0]  flg;
  int          lat, nreq, d0, rb0;
  bit          seen;

  initial begin
    bus.START = 1'b0; bus.OPA = '0; bus.OPB = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    div_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",   32'(bus.BUSY),    32'd0);
    chk("rst_done",   32'(bus.DONE),    32'd0);
    chk("rst_result", bus.RESULT,       32'd0);
    chk("rst_flags",  32'(bus.FLAGS),   32'd0);
    chk("rst_divreq", 32'(bus.DIV_REQ), 32'd0);
    chk("rst_diva",   32'(bus.DIV_A),   32'd0);
    chk("rst_divb",   32'(bus.DIV_B),   32'd0);

    run_op("6div2", 32'h40C00000, 32'h40000000, res, flg, lat, nreq);
    chk("6div2_res", res, 32'h40400000);
    chk("6div2_flg", 32'(flg), 32'h0);
    chk("6div2_req", 32'(nreq), 32'd1);

    run_op("1div3", 32'h3F800000, 32'h40400000, res, flg, lat, nreq);
    chk("1div3_res", res, 32'h3EAAAAAA);
    chk("1div3_flg", 32'(flg), 32'h0);

    run_op("1div0", 32'h3F800000, 32'h00000000, res, flg, lat, nreq);
    chk("1div0_res", res, 32'h7F800000);
    chk("1div0_flg", 32'(flg), 32'h4);
    chk("1div0_req", 32'(nreq), 32'd0);
    chk("1div0_lat", 32'(lat), 32'd3);

    run_op("0div0", 32'h00000000, 32'h00000000, res, flg, lat, nreq);
    chk("0div0_res", res, 32'h7FC00000);
    chk("0div0_flg", 32'(flg), 32'h8);
    chk("0div0_req", 32'(nreq), 32'd0);
    chk("0div0_lat", 32'(lat), 32'd3);

    run_op("ovf", 32'h7F000000, 32'h3E800000, res, flg, lat, nreq);
    chk("ovf_res", res, 32'h7F800000);
    chk("ovf_flg", 32'(flg), 32'h2);

    run_op("unf", 32'h00800000, 32'h7F000000, res, flg, lat, nreq);
    chk("unf_res", res, 32'h00000000);
    chk("unf_flg", 32'(flg), 32'h1);

    run_op("neg6div2", 32'hC0C00000, 32'h40000000, res, flg, lat, nreq);
    chk("neg6div2_res", res, 32'hC0400000);
    chk("neg6div2_flg", 32'(flg), 32'h0);

    run_op("nandiv1", 32'h7FC00001, 32'h3F800000, res, flg, lat, nreq);
    chk("nandiv1_res", res, 32'h7FC00000);
    chk("nandiv1_flg", 32'(flg), 32'h8);

    run_op("infdiv0", 32'hFF800000, 32'h00000000, res, flg, lat, nreq);
    chk("infdiv0_res", res, 32'hFF800000);
    chk("infdiv0_flg", 32'(flg), 32'h0);

    run_op("1divinf", 32'h3F800000, 32'hFF800000, res, flg, lat, nreq);
    chk("1divinf_res", res, 32'h80000000);
    chk("1divinf_flg", 32'(flg), 32'h0);

    run_op("ftz", 32'h80400000, 32'h3F800000, res, flg, lat, nreq);
    chk("ftz_res", res, 32'h80000000);
    chk("ftz_flg", 32'(flg), 32'h0);
    chk("ftz_req", 32'(nreq), 32'd0);

    // Second START while BUSY must be dropped.
    d0 = done_cnt;
    @(negedge clk); bus.START = 1'b1; bus.OPA = 32'h40C00000; bus.OPB = 32'h40000000;
    @(negedge clk); bus.START = 1'b0;
    @(negedge clk); bus.START = 1'b1; bus.OPA = 32'h3F800000; bus.OPB = 32'h40400000;
    @(negedge clk); bus.START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.DONE) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("busyign_done_seen", 32'(seen), 32'd1);
    chk("busyign_res", bus.RESULT, 32'h40400000);
    repeat (30) @(negedge clk);
    chk("busyign_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset while the divider is mid-operation, then a fresh 6/2.
    div_lat = 20;
    @(negedge clk); bus.START = 1'b1; bus.OPA = 32'h40C00000; bus.OPB = 32'h40000000;
    @(negedge clk); bus.START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.DIV_REQ) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("rstwait_req_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    d0 = done_cnt; rb0 = req_busy_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_busy", 32'(bus.BUSY), 32'd0);
    rst = 1'b0;
    div_lat = 6;
    run_op("rstwait", 32'h40C00000, 32'h40000000, res, flg, lat, nreq);
    chk("rstwait_res", res, 32'h40400000);
    chk("rstwait_flg", 32'(flg), 32'h0);
    chk("rstwait_req", 32'(nreq), 32'd1);
    chk("rstwait_req_vs_ready", 32'(req_busy_cnt - rb0), 32'd0);
    chk("rstwait_ndone", 32'(done_cnt - d0), 32'd1);

`ifdef FDIV_TIMEOUT_EN
    // Divider never completes: forced invalid after TIMEOUT cycles in WAIT.
    repeat (3) @(negedge clk);
    div_lat = 1000;
    run_op("tmo", 32'h40C00000, 32'h40000000, res, flg, lat, nreq);
    chk("tmo_res", res, 32'h7FC00000);
    chk("tmo_flg", 32'(flg), 32'h8);
    chk("tmo_lat_window", 32'(lat >= 66 && lat <= 70), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
